// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between NUM_REQ writeback sources.
// Optional read-after-write scoreboard enabled by defining REGFILE_ARB_SCOREBOARD_EN.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0][4:0]  req_addr,
    input  logic [NUM_REQ-1:0][31:0] req_data,
    output logic                     w_en,
    output logic [4:0]               w_addr,
    output logic [31:0]              w_data,
    input  logic                     issue_valid,
    input  logic [4:0]               issue_rd,
    input  logic [4:0]               rs1_addr,
    input  logic [4:0]               rs2_addr,
    output logic                     rs1_busy,
    output logic                     rs2_busy
);

    localparam int          PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned NREQ  = NUM_REQ;

    logic [PTR_W-1:0] r_rr_ptr;
    logic [PTR_W-1:0] w_gnt_idx;
    logic             w_gnt_any;
    logic [4:0]       w_gnt_addr;
    logic [31:0]      w_gnt_data;
    logic             w_wr;
    logic             r_w_en;
    logic [4:0]       r_w_addr;
    logic [31:0]      r_w_data;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] base,
                                                  input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NREQ) sum = sum - NREQ;
        return sum[PTR_W-1:0];
    endfunction

    // Grant: first valid requester scanning upward from the pointer, with wrap-around
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = r_rr_ptr;
        req_ready = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!w_gnt_any && req_valid[wrap_inc(r_rr_ptr, k)]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = wrap_inc(r_rr_ptr, k);
            end
        end
        if (w_gnt_any) req_ready[w_gnt_idx] = 1'b1;
    end

    assign w_gnt_addr = req_addr[w_gnt_idx];
    assign w_gnt_data = req_data[w_gnt_idx];
    // An x0 request still consumes its turn but never produces a write
    assign w_wr       = w_gnt_any && (w_gnt_addr != 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_w_en   <= 1'b0;
            r_w_addr <= 5'd0;
            r_w_data <= 32'd0;
        end else begin
            r_w_en <= w_wr;
            if (w_gnt_any) r_rr_ptr <= wrap_inc(w_gnt_idx, 1);
            if (w_wr) begin
                r_w_addr <= w_gnt_addr;
                r_w_data <= w_gnt_data;
            end
        end
    end

    assign w_en   = r_w_en;
    assign w_addr = r_w_addr;
    assign w_data = r_w_data;

`ifdef REGFILE_ARB_SCOREBOARD_EN
    logic [31:0] r_busy;
    logic [31:0] w_busy_nxt;

    // Clear on the retiring write first so a same-edge issue of that register wins
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_w_en) w_busy_nxt[r_w_addr] = 1'b0;
        if (issue_valid && (issue_rd != 5'd0)) w_busy_nxt[issue_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_busy <= '0;
        else     r_busy <= w_busy_nxt;
    end

    assign rs1_busy = r_busy[rs1_addr];
    assign rs2_busy = r_busy[rs2_addr];
`else
    logic w_unused_sb;
    assign w_unused_sb = ^{issue_valid, issue_rd, rs1_addr, rs2_addr};
    assign rs1_busy    = 1'b0;
    assign rs2_busy    = 1'b0;
`endif

endmodule
